guess_code_engine: RTL
======================

Name: guess_code_engine

Overview:
- Clocked, parametrised two-player code-guessing engine. Player A enters a secret sequence of button symbols; player B then has a limited number of tries to reproduce it.
- Per try it reports a positional hit count, a length comparison and win/lose.
- Sits between the debounced push-button front end and the 7-segment/LED display logic.
- Generalises the button count, the code lengths and the try budget, and adds hit scoring and explicit tries-left reporting.

Parameters:
- N_BTN, 4, number of symbol buttons (2..16)
- MAX_LEN, 7, maximum symbols per sequence
- MIN_LEN, 4, minimum symbols before enter is accepted (1..MAX_LEN)
- MAX_TRIES, 4, guesses allowed before lose

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn  in  N_BTN  debounced, clk-synchronous button levels
- enter  in  1  debounced, clk-synchronous submit level
- phase  out  2  0=SET 1=GUESS 2=CHECK 3=DONE
- secret_len  out  $clog2(MAX_LEN+1)  symbols stored for the secret
- guess_len  out  $clog2(MAX_LEN+1)  symbols in the current guess
- hits  out  $clog2(MAX_LEN+1)  positional matches of the last checked guess
- len_cmp  out  2  last guess length vs secret: 0=EQ 1=SHORTER 2=LONGER
- tries_left  out  $clog2(MAX_TRIES+1)  remaining guesses
- result_valid  out  1  one-cycle pulse when hits/len_cmp/win/lose update
- win  out  1  sticky, secret matched
- lose  out  1  sticky, tries exhausted

Behaviour:
- Reset (async assert, sync release): phase=SET, all lengths/hits/len_cmp=0, tries_left=MAX_TRIES, result_valid/win/lose=0, both buffers cleared.
- Event detection: btn and enter are registered once; an event is a 0->1 transition.
  - A held input produces one event only.
  - Exactly one btn rising edge in a cycle is a symbol event; its value is the bit index (0..N_BTN-1).
  - Two or more simultaneous btn edges are discarded.
  - If an enter event and a symbol event occur in the same cycle, the symbol is discarded and enter is evaluated on the current length.
- SET phase:
  - A symbol event appends at position secret_len, then secret_len+1.
  - When secret_len reaches MAX_LEN, go to GUESS on the next cycle.
  - Enter with secret_len>=MIN_LEN goes to GUESS. Enter with secret_len<MIN_LEN is ignored.
- GUESS phase:
  - A symbol event appends to the guess buffer while guess_len<MAX_LEN; further symbols are ignored (no auto-submit).
  - Enter with guess_len>=MIN_LEN goes to CHECK. Enter with a shorter guess is ignored.
- CHECK phase: serial scan of exactly MAX_LEN cycles.
  - Position i counts as a hit iff i<secret_len, i<guess_len and the symbols are equal.
  - All input events during CHECK are dropped.
  - On the cycle after the last scan position:
    - result_valid=1; hits and len_cmp are registered.
    - If hits==secret_len and guess_len==secret_len: win=1, phase=DONE.
    - Otherwise tries_left-=1. If the new value is 0: lose=1, phase=DONE. If not: clear the guess buffer, guess_len=0, return to GUESS.
- Latency: enter edge visible on the registered input -> result_valid is MAX_LEN+1 cycles.
- DONE phase: every output holds and all events are ignored until reset.
- Reset mid-operation (any phase, including mid-CHECK) aborts immediately to reset values; no result_valid pulse is produced.
- Arithmetic:
  - Symbol storage width is $clog2(N_BTN), minimum 1.
  - Counters saturate and can never wrap: lengths at MAX_LEN, tries_left at 0.

Decomposition:
- Shared package guess_pkg: the phase enum (SET/GUESS/CHECK/DONE), the len_cmp encodings (EQ/SHORTER/LONGER), and width helper constants derived from N_BTN/MAX_LEN/MAX_TRIES.
- One sub-module, btn_edge_encoder:
  - Registers btn and enter and detects rising edges.
  - Encodes a one-hot symbol to an index and flags multi-press rejection.
  - Outputs sym_valid, sym, enter_evt.

Test Plan:
1. Secret 0,1,2,3 + enter; guess 0,1,2,3 + enter -> result_valid exactly 8 cycles after the enter edge, hits=4, len_cmp=EQ, win=1, phase=DONE, tries_left=4.
2. Secret 0,1,2,3; four guesses of 3,3,3,3 -> hits=1 each time, tries_left 3,2,1,0, lose=1 after the fourth, later events ignored.
3. Secret of 7 presses with no enter -> phase=GUESS automatically, secret_len=7. Then guess 0,1,2 + enter -> ignored (guess_len=3<MIN_LEN), phase remains GUESS.
4. Secret 0,1,2,3,0 (len 5); guess 0,1,2,3 + enter -> hits=4, len_cmp=SHORTER, no win, tries_left=3, guess_len cleared to 0.
5. btn[1] held for 10 cycles -> one symbol only. btn[0] and btn[2] rising in the same cycle -> no symbol stored. Symbol plus enter in the same cycle -> symbol dropped.
6. Assert reset during cycle 3 of CHECK -> outputs immediately take reset values, no result_valid pulse, phase=SET.

Source files
------------

// File: rtl/guess_pkg.sv
// ---------------------------------------------------------------------------
// guess_pkg
// Shared types and width helpers for the two-player code-guessing engine.
//   phase_t    : SET / GUESS / CHECK / DONE game phase
//   len_cmp_t  : guess length relative to secret length (EQ / SHORTER / LONGER)
//   DEF_*      : default parameter values used by the engine
//   symWidth   : bits needed to store one button index (never below 1)
//   cntWidth   : bits needed for a counter that runs 0..maxVal
//   idxWidth   : bits needed to address a buffer of the given depth
// ---------------------------------------------------------------------------
package guess_pkg;

   typedef enum logic [1:0] {
      PH_SET   = 2'd0,
      PH_GUESS = 2'd1,
      PH_CHECK = 2'd2,
      PH_DONE  = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      LC_EQ      = 2'd0,
      LC_SHORTER = 2'd1,
      LC_LONGER  = 2'd2
   } len_cmp_t;

   localparam int DEF_N_BTN     = 4;
   localparam int DEF_MAX_LEN   = 7;
   localparam int DEF_MIN_LEN   = 4;
   localparam int DEF_MAX_TRIES = 4;

   // A two-button panel still needs one bit per stored symbol.
   function automatic int symWidth(input int nBtn);
      return (nBtn > 2) ? $clog2(nBtn) : 1;
   endfunction

   function automatic int cntWidth(input int maxVal);
      return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
   endfunction

   function automatic int idxWidth(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/btn_edge_encoder.sv
// ---------------------------------------------------------------------------
// btn_edge_encoder
// Turns debounced button/enter levels into single-cycle events.
//   clk, reset : system clock, asynchronous active-high reset
//   btn        : debounced button levels, one bit per symbol
//   enter      : debounced submit level
//   sym_valid  : exactly one button rose this cycle
//   sym        : index of that button (only meaningful with sym_valid)
//   enter_evt  : enter rose this cycle
// ---------------------------------------------------------------------------
module btn_edge_encoder
   import guess_pkg::*;
#(
   parameter int N_BTN = DEF_N_BTN,
   parameter int SYM_W = symWidth(DEF_N_BTN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn,
   input  logic             enter,
   output logic             sym_valid,
   output logic [SYM_W-1:0] sym,
   output logic             enter_evt
);

   logic [N_BTN-1:0] r_btn;
   logic [N_BTN-1:0] r_btnPrev;
   logic             r_enter;
   logic             r_enterPrev;
   logic [N_BTN-1:0] w_rise;
   logic [SYM_W-1:0] w_sym;

   // Register the inputs once, then keep one more copy so a rising edge is
   // seen exactly once no matter how long a button is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn       <= '0;
         r_btnPrev   <= '0;
         r_enter     <= 1'b0;
         r_enterPrev <= 1'b0;
      end else begin
         r_btn       <= btn;
         r_btnPrev   <= r_btn;
         r_enter     <= enter;
         r_enterPrev <= r_enter;
      end
   end

   assign w_rise = r_btn & ~r_btnPrev;

   // Priority-free encoder: only used when w_rise is one-hot, so whichever
   // bit the loop lands on is the single pressed button.
   always_comb begin
      w_sym = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (w_rise[i]) begin
            w_sym = SYM_W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves zero only for a one-hot vector, which
   // is how simultaneous presses get rejected.
   assign sym_valid = (w_rise != '0) && ((w_rise & (w_rise - 1'b1)) == '0);
   assign sym       = w_sym;
   assign enter_evt = r_enter & ~r_enterPrev;

endmodule

// File: rtl/guess_code_engine.sv
// ---------------------------------------------------------------------------
// guess_code_engine
// Two-player code-guessing game: player A stores a secret symbol sequence,
// player B gets MAX_TRIES attempts to reproduce it.
//   clk, reset   : system clock, asynchronous active-high reset
//   btn, enter   : debounced, clk-synchronous button and submit levels
//   phase        : 0=SET 1=GUESS 2=CHECK 3=DONE
//   secret_len   : symbols stored for the secret
//   guess_len    : symbols in the current guess
//   hits         : positional matches of the last checked guess
//   len_cmp      : last guess length vs secret (0=EQ 1=SHORTER 2=LONGER)
//   tries_left   : remaining guesses
//   result_valid : one-cycle pulse when hits/len_cmp/win/lose update
//   win, lose    : sticky game outcome
// ---------------------------------------------------------------------------
module guess_code_engine
   import guess_pkg::*;
#(
   parameter int N_BTN     = DEF_N_BTN,
   parameter int MAX_LEN   = DEF_MAX_LEN,
   parameter int MIN_LEN   = DEF_MIN_LEN,
   parameter int MAX_TRIES = DEF_MAX_TRIES
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_BTN-1:0]                 btn,
   input  logic                             enter,
   output logic [1:0]                       phase,
   output logic [cntWidth(MAX_LEN)-1:0]     secret_len,
   output logic [cntWidth(MAX_LEN)-1:0]     guess_len,
   output logic [cntWidth(MAX_LEN)-1:0]     hits,
   output logic [1:0]                       len_cmp,
   output logic [cntWidth(MAX_TRIES)-1:0]   tries_left,
   output logic                             result_valid,
   output logic                             win,
   output logic                             lose
);

   localparam int SYM_W = symWidth(N_BTN);
   localparam int LEN_W = cntWidth(MAX_LEN);
   localparam int TRY_W = cntWidth(MAX_TRIES);
   localparam int IDX_W = idxWidth(MAX_LEN);

   logic             w_symValid;
   logic [SYM_W-1:0] w_sym;
   logic             w_enterEvt;
   logic             w_symAccept;

   phase_t           r_phase;
   phase_t           w_phaseNext;

   logic [SYM_W-1:0] r_secret [MAX_LEN];
   logic [SYM_W-1:0] r_guess  [MAX_LEN];
   logic [LEN_W-1:0] r_secretLen;
   logic [LEN_W-1:0] r_guessLen;
   logic [IDX_W-1:0] r_scanIdx;
   logic [LEN_W-1:0] r_hitAcc;
   logic [LEN_W-1:0] r_hits;
   len_cmp_t         r_lenCmp;
   logic [TRY_W-1:0] r_triesLeft;
   logic             r_resultValid;
   logic             r_win;
   logic             r_lose;

   logic             w_scanLast;
   logic             w_hitNow;
   logic [LEN_W-1:0] w_hitsTotal;
   logic             w_isWin;
   logic [TRY_W-1:0] w_triesDec;
   len_cmp_t         w_lenCmp;

   btn_edge_encoder #(
      .N_BTN (N_BTN),
      .SYM_W (SYM_W)
   ) u_edge (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .enter     (enter),
      .sym_valid (w_symValid),
      .sym       (w_sym),
      .enter_evt (w_enterEvt)
   );

   // Enter wins over a symbol arriving in the same cycle, so the length that
   // enter is judged against is the one the player actually saw.
   assign w_symAccept = w_symValid & ~w_enterEvt;

   // Scan arithmetic for the serial compare: one buffer position per cycle,
   // positions past either length never count.
   assign w_scanLast  = (r_phase == PH_CHECK) && (r_scanIdx == IDX_W'(MAX_LEN - 1));
   assign w_hitNow    = (LEN_W'(r_scanIdx) < r_secretLen) &&
                        (LEN_W'(r_scanIdx) < r_guessLen) &&
                        (r_secret[r_scanIdx] == r_guess[r_scanIdx]);
   assign w_hitsTotal = r_hitAcc + LEN_W'(w_hitNow);
   assign w_isWin     = (w_hitsTotal == r_secretLen) && (r_guessLen == r_secretLen);
   assign w_triesDec  = (r_triesLeft != '0) ? (r_triesLeft - 1'b1) : '0;

   always_comb begin
      w_lenCmp = LC_EQ;
      if (r_guessLen < r_secretLen) begin
         w_lenCmp = LC_SHORTER;
      end else if (r_guessLen > r_secretLen) begin
         w_lenCmp = LC_LONGER;
      end
   end

   // Phase register. Reset is expected to be released synchronously to clk
   // by the front end that drives it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= PH_SET;
      end else begin
         r_phase <= w_phaseNext;
      end
   end

   // Next-phase decision. A full secret moves to GUESS on its own; enter is
   // only honoured once the minimum length has been reached.
   always_comb begin
      w_phaseNext = r_phase;
      case (r_phase)
         PH_SET: begin
            if ((w_enterEvt && (r_secretLen >= LEN_W'(MIN_LEN))) ||
                (r_secretLen == LEN_W'(MAX_LEN))) begin
               w_phaseNext = PH_GUESS;
            end
         end
         PH_GUESS: begin
            if (w_enterEvt && (r_guessLen >= LEN_W'(MIN_LEN))) begin
               w_phaseNext = PH_CHECK;
            end
         end
         PH_CHECK: begin
            if (w_scanLast) begin
               if (w_isWin || (w_triesDec == '0)) begin
                  w_phaseNext = PH_DONE;
               end else begin
                  w_phaseNext = PH_GUESS;
               end
            end
         end
         PH_DONE: begin
            w_phaseNext = PH_DONE;
         end
         default: begin
            w_phaseNext = PH_SET;
         end
      endcase
   end

   // Datapath: symbol buffers, length counters, the scan accumulator and the
   // registered result. Everything in here is frozen once the game is DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            r_secret[i] <= '0;
            r_guess[i]  <= '0;
         end
         r_secretLen   <= '0;
         r_guessLen    <= '0;
         r_scanIdx     <= '0;
         r_hitAcc      <= '0;
         r_hits        <= '0;
         r_lenCmp      <= LC_EQ;
         r_triesLeft   <= TRY_W'(MAX_TRIES);
         r_resultValid <= 1'b0;
         r_win         <= 1'b0;
         r_lose        <= 1'b0;
      end else begin
         r_resultValid <= 1'b0;
         case (r_phase)
            PH_SET: begin
               if (w_symAccept && (r_secretLen < LEN_W'(MAX_LEN))) begin
                  r_secret[IDX_W'(r_secretLen)] <= w_sym;
                  r_secretLen                   <= r_secretLen + 1'b1;
               end
            end
            PH_GUESS: begin
               if (w_symAccept && (r_guessLen < LEN_W'(MAX_LEN))) begin
                  r_guess[IDX_W'(r_guessLen)] <= w_sym;
                  r_guessLen                  <= r_guessLen + 1'b1;
               end
            end
            PH_CHECK: begin
               r_hitAcc  <= w_hitsTotal;
               r_scanIdx <= r_scanIdx + 1'b1;
               if (w_scanLast) begin
                  r_resultValid <= 1'b1;
                  r_hits        <= w_hitsTotal;
                  r_lenCmp      <= w_lenCmp;
                  r_hitAcc      <= '0;
                  r_scanIdx     <= '0;
                  if (w_isWin) begin
                     r_win <= 1'b1;
                  end else begin
                     r_triesLeft <= w_triesDec;
                     if (w_triesDec == '0) begin
                        r_lose <= 1'b1;
                     end else begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                           r_guess[i] <= '0;
                        end
                        r_guessLen <= '0;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign phase        = r_phase;
   assign secret_len   = r_secretLen;
   assign guess_len    = r_guessLen;
   assign hits         = r_hits;
   assign len_cmp      = r_lenCmp;
   assign tries_left   = r_triesLeft;
   assign result_valid = r_resultValid;
   assign win          = r_win;
   assign lose         = r_lose;

endmodule
